multicycle_controller: RTL and testbench

Moore-style control FSM for the team's multi-cycle RISC-V datapath, the successor to the single-cycle core. It sequences one shared ALU and one unified instruction/data memory across several cycles per instruction. It decodes `op`, `funct3` and `funct7` from the datapath's instruction register. It drives every mux select, write enable and ALU operation, and uses `Zero` and `ALUResSign` to resolve branches.

---
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM.
// Sequences the shared ALU and unified memory per instruction.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResSign,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALRADR,
    S_JALRPC, S_LUI
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_alu_r;
  logic [2:0] w_alu_i;
  logic       w_take;
  logic       w_unused;

  assign w_unused = ^{funct7[6], funct7[4:0]};

  // ALU operation for R-type and I-ALU; I-ALU never subtracts
  always_comb begin
    w_alu_r = ALU_ADD;
    w_alu_i = ALU_ADD;
    case (funct3)
      3'b000: begin
        w_alu_r = funct7[5] ? ALU_SUB : ALU_ADD;
        w_alu_i = ALU_ADD;
      end
      3'b111: begin
        w_alu_r = ALU_AND;
        w_alu_i = ALU_AND;
      end
      3'b110: begin
        w_alu_r = ALU_OR;
        w_alu_i = ALU_OR;
      end
      3'b100: begin
        w_alu_r = ALU_XOR;
        w_alu_i = ALU_XOR;
      end
      3'b010: begin
        w_alu_r = ALU_SLT;
        w_alu_i = ALU_SLT;
      end
      default: begin
        w_alu_r = ALU_ADD;
        w_alu_i = ALU_ADD;
      end
    endcase
  end

  // Branch resolution from the flags of rs1 - rs2
  always_comb begin
    w_take = 1'b0;
    case (funct3)
      3'b000:  w_take = Zero;
      3'b001:  w_take = ~Zero;
      3'b100:  w_take = ALUResSign;
      3'b101:  w_take = ~ALUResSign;
      default: w_take = 1'b0;
    endcase
  end

  // State register; reset forces FETCH without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state and control outputs per state
  always_comb begin
    w_next     = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW:   w_next = S_MEMADR;
          OP_SW: begin
            ImmSrc = IMM_S;
            w_next = S_MEMADR;
          end
          OP_R:    w_next = S_EXECR;
          OP_I:    w_next = S_EXECI;
          OP_BR: begin
            ImmSrc = IMM_B;
            w_next = S_BRANCH;
          end
          OP_JAL: begin
            ImmSrc = IMM_J;
            w_next = S_JAL;
          end
          OP_JALR: w_next = S_JALRADR;
          OP_LUI: begin
            ImmSrc = IMM_U;
            w_next = S_LUI;
          end
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_SW) begin
          ImmSrc = IMM_S;
          w_next = S_MEMWRITE;
        end else begin
          w_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_r;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_i;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        ImmSrc     = IMM_B;
        PCWrite    = w_take;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        ImmSrc  = IMM_J;
        w_next  = S_ALUWB;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = S_JALRPC;
      end
      S_JALRPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        w_next  = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        ImmSrc    = IMM_U;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction
// output recipes from the ISA rules, directed then random.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       Zero = 1'b0;
  logic       ALUResSign = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic       illegal;

  int n_chk = 0;
  int n_fail = 0;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .ALUResSign(ALUResSign),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // bit layout: [17]PCW [16]Adr [15]MemW [14]IRW [13]RegW
  // [12:11]Res [10:9]SrcA [8:7]SrcB [6:4]Imm [3:1]ALU [0]ill
  wire [17:0] w_dut = {PCWrite, AdrSrc, MemWrite, IRWrite,
                       RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                       ImmSrc, ALUControl, illegal};

  function automatic logic [17:0] mk(
    input logic pcw, adr, mw, irw, rw,
    input logic [1:0] rs, sa, sb,
    input logic [2:0] imm, alu,
    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  function automatic logic [17:0] fetch_v();
    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 0);
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3,
                                        input logic sub);
    case (f3)
      3'b000:  return sub ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b010:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic take_of(input logic [2:0] f3,
                                   input logic z, s);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      3'b101:  return !s;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output per cycle of one instruction
  function automatic void build(input logic [6:0] o,
                                input logic [2:0] f3,
                                input logic [6:0] f7,
                                input logic z, s);
    logic [17:0] wb;
    logic [2:0] imm;
    logic ill;
    wb = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 0);
    ill = 0;
    case (o)
      7'b0100011: imm = 3'd1;
      7'b1100011: imm = 3'd2;
      7'b1101111: imm = 3'd3;
      7'b0110111: imm = 3'd4;
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b1100111: imm = 3'd0;
      default: begin
        imm = 3'd0;
        ill = 1;
      end
    endcase
    exp_q.push_back(fetch_v());
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01,
                       imm, 3'd0, ill));
    case (o)
      7'b0000011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0));
      end
      7'b0100011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      7'b0110011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0,
                           alu_of(f3, f7[5]), 0));
        exp_q.push_back(wb);
      end
      7'b0010011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0,
                           alu_of(f3, 1'b0), 0));
        exp_q.push_back(wb);
      end
      7'b1100011:
        exp_q.push_back(mk(take_of(f3, z, s), 0, 0, 0, 0, 0,
                           2'b10, 2'b00, 3'd2, 3'd1, 0));
      7'b1101111: begin
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'd3, 0, 0));
        exp_q.push_back(wb);
      end
      7'b1100111: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0));
        exp_q.push_back(wb);
      end
      7'b0110111:
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b11, 0, 0, 3'd4, 0, 0));
      default: ;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; returns at next FETCH
  task automatic run(input logic [6:0] o, input logic [2:0] f3,
                     input logic [6:0] f7, input logic z, s);
    op = o;
    funct3 = f3;
    funct7 = f7;
    Zero = z;
    ALUResSign = s;
    exp_q.delete();
    got_q.delete();
    build(o, f3, f7, z, s);
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      chk($sformatf("op=%b f3=%b f7=%b z=%b s=%b cyc%0d",
                    o, f3, f7, z, s, i),
          {14'd0, w_dut}, {14'd0, exp_q[i]});
      got_q.push_back(w_dut);
      @(negedge clk);
    end
  endtask

  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                         7'b0100011, 7'b1100111, 7'b1100011,
                         7'b1101111, 7'b0110111, 7'b0000000};

  initial begin
    logic rw_any;
    logic [31:0] rnd;
    logic [6:0] ro;
    logic [6:0] rf7;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_held_fetch", {14'd0, w_dut}, {14'd0, fetch_v()});
    chk("reset_irwrite", {31'd0, IRWrite}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run(7'b0110011, 3'b000, 7'b0000000, 0, 0);
    chk("add_exec_alu", {29'd0, got_q[2][3:1]}, 32'd0);
    chk("add_wb_regwrite", {31'd0, got_q[3][13]}, 32'd1);
    chk("add_wb_ressrc", {30'd0, got_q[3][12:11]}, 32'd0);
    run(7'b0110011, 3'b000, 7'b0100000, 0, 0);
    chk("sub_exec_alu", {29'd0, got_q[2][3:1]}, 32'd1);
    run(7'b0010011, 3'b000, 7'b1111111, 0, 0);
    chk("addi_f7_alu", {29'd0, got_q[2][3:1]}, 32'd0);
    run(7'b0000011, 3'b010, 7'b0, 0, 0);
    chk("lw_wb_ressrc", {30'd0, got_q[4][12:11]}, 32'd1);
    chk("lw_wb_regwrite", {31'd0, got_q[4][13]}, 32'd1);
    run(7'b0100011, 3'b010, 7'b0, 0, 0);
    chk("sw_memwrite", {31'd0, got_q[3][15]}, 32'd1);
    chk("sw_adrsrc", {31'd0, got_q[3][16]}, 32'd1);
    rw_any = 0;
    foreach (got_q[i]) rw_any |= got_q[i][13];
    chk("sw_no_regwrite", {31'd0, rw_any}, 32'd0);
    run(7'b1100011, 3'b000, 7'b0, 1, 0);
    chk("beq_taken", {31'd0, got_q[2][17]}, 32'd1);
    run(7'b1100011, 3'b000, 7'b0, 0, 0);
    chk("beq_not_taken", {31'd0, got_q[2][17]}, 32'd0);
    run(7'b1100011, 3'b100, 7'b0, 0, 1);
    chk("blt_taken", {31'd0, got_q[2][17]}, 32'd1);
    run(7'b1100011, 3'b101, 7'b0, 0, 1);
    chk("bge_not_taken", {31'd0, got_q[2][17]}, 32'd0);
    run(7'b1100011, 3'b010, 7'b0, 1, 1);
    chk("br_f3_010", {31'd0, got_q[2][17]}, 32'd0);
    run(7'b1101111, 3'b000, 7'b0, 0, 0);
    chk("jal_pcwrite", {31'd0, got_q[2][17]}, 32'd1);
    chk("jal_wb", {31'd0, got_q[3][13]}, 32'd1);
    run(7'b1100111, 3'b000, 7'b0, 0, 0);
    chk("jalrpc_pcwrite", {31'd0, got_q[3][17]}, 32'd1);
    chk("jalr_wb", {31'd0, got_q[4][13]}, 32'd1);
    run(7'b0110111, 3'b000, 7'b0, 0, 0);
    chk("lui_ressrc", {30'd0, got_q[2][12:11]}, 32'd3);
    chk("lui_immsrc", {29'd0, got_q[2][6:4]}, 32'd4);
    run(7'b0000000, 3'b000, 7'b0, 0, 0);
    chk("illegal_pulse", {31'd0, got_q[1][0]}, 32'd1);
    chk("illegal_no_we",
        {29'd0, got_q[1][17], got_q[1][15], got_q[1][13]}, 32'd0);

    op = 7'b0000011;
    funct3 = 3'b010;
    repeat (3) @(negedge clk);
    #1;
    chk("memread_before_rst", {31'd0, AdrSrc}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_fetch", {14'd0, w_dut}, {14'd0, fetch_v()});
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      rnd = $urandom();
      ro = rnd[6:0];
      if (rnd[10:7] < 4'd14) ro = ops[rnd[10:7] % 9];
      rf7 = rnd[11] ? 7'b0100000 : rnd[18:12];
      run(ro, rnd[21:19], rf7, rnd[22], rnd[23]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
